// File: rtl/ad9767_sweep_ctrl.sv
// Frequency-sweep scheduler for the dual AD9767 DAC path: walks a list of FCWs through a
// phase accumulator and drives the DA1/DA2 sine-ROM addresses (DA2 with a fixed offset).
module ad9767_sweep_ctrl #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int STEP_W  = 16,
  parameter int DWELL_W = 24
) (
  input  logic               clk_125,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_en,
  input  logic [PHASE_W-1:0] fcw_start,
  input  logic [PHASE_W-1:0] fcw_step,
  input  logic [STEP_W-1:0]  n_steps,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [ADDR_W-1:0]  ch2_phase,
  output logic [ADDR_W-1:0]  rom_addr1,
  output logic [ADDR_W-1:0]  rom_addr2,
  output logic               dac_en,
  output logic               busy,
  output logic               done,
  output logic [STEP_W-1:0]  step_idx
);

  // state  | meaning
  // IDLE   | waiting for start; outputs parked, dac_en low
  // RUN    | accumulator advancing, dwell counter stepping through the FCW list
  // DONE   | single pass finished; done pulse is issued on leaving this state
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] fcw;
  logic [PHASE_W-1:0] fcw_start_r;
  logic [PHASE_W-1:0] fcw_step_r;
  logic [STEP_W-1:0]  n_last_r;
  logic [STEP_W-1:0]  step_cnt;
  logic [DWELL_W-1:0] dwell_last_r;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [ADDR_W-1:0]  ch2_phase_r;
  logic [ADDR_W-1:0]  acc_top;
  logic               launch;
  logic               dwell_hit;
  logic               last_step;

  assign acc_top   = acc[PHASE_W-1 -: ADDR_W];
  assign dwell_hit = (dwell_cnt == dwell_last_r);
  assign last_step = (step_cnt == n_last_r);

  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The done cycle is still the tail of DONE as seen from outside, so start is not taken there.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort && !done) begin
          state_d = S_RUN;
          launch  = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (dwell_hit && last_step && !loop_en) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      fcw          <= '0;
      fcw_start_r  <= '0;
      fcw_step_r   <= '0;
      n_last_r     <= '0;
      dwell_last_r <= '0;
      dwell_cnt    <= '0;
      step_cnt     <= '0;
      ch2_phase_r  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            fcw_start_r  <= fcw_start;
            fcw_step_r   <= fcw_step;
            n_last_r     <= (n_steps == '0) ? '0 : n_steps - STEP_W'(1);
            dwell_last_r <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            ch2_phase_r  <= ch2_phase;
            acc          <= '0;
            fcw          <= fcw_start;
            dwell_cnt    <= '0;
            step_cnt     <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            acc <= '0;
          end else begin
            acc <= acc + fcw;
            if (dwell_hit) begin
              dwell_cnt <= '0;
              if (!last_step) begin
                fcw      <= fcw + fcw_step_r;
                step_cnt <= step_cnt + STEP_W'(1);
              end else if (loop_en) begin
                // acc deliberately keeps running so the restart is phase-continuous
                fcw      <= fcw_start_r;
                step_cnt <= '0;
              end
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
          end
        end
        S_DONE: begin
          if (abort) begin
            acc <= '0;
          end
        end
        default: acc <= '0;
      endcase
    end
  end

  // Output registers sample the current accumulator, so addresses trail acc by one clock.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr1 <= '0;
      rom_addr2 <= '0;
      step_idx  <= '0;
      dac_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      dac_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      if (state_q == S_RUN && !abort) begin
        rom_addr1 <= acc_top;
        rom_addr2 <= acc_top + ch2_phase_r;
        step_idx  <= step_cnt;
        dac_en    <= 1'b1;
        busy      <= 1'b1;
      end
      if (state_q == S_DONE && !abort) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ad9767_sweep_ctrl.sv
// Directed bench for ad9767_sweep_ctrl: single pass, phase offset, loop, zero config,
// abort, accumulator wrap and asynchronous reset, with hand-computed address sequences.
module tb_ad9767_sweep_ctrl;

  logic        clk_125;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        loop_en;
  logic [31:0] fcw_start;
  logic [31:0] fcw_step;
  logic [15:0] n_steps;
  logic [23:0] dwell;
  logic [9:0]  ch2_phase;
  logic [9:0]  rom_addr1;
  logic [9:0]  rom_addr2;
  logic        dac_en;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;

  int vectors = 0;
  int errors  = 0;

  ad9767_sweep_ctrl dut (
    .clk_125  (clk_125),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .loop_en  (loop_en),
    .fcw_start(fcw_start),
    .fcw_step (fcw_step),
    .n_steps  (n_steps),
    .dwell    (dwell),
    .ch2_phase(ch2_phase),
    .rom_addr1(rom_addr1),
    .rom_addr2(rom_addr2),
    .dac_en   (dac_en),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  initial clk_125 = 1'b0;
  always #4 clk_125 = ~clk_125;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one clock; returns at the negedge of the first RUN state cycle,
  // whose registered outputs are not yet busy.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_125);
    start = 1'b0;
  endtask

  int exp1 [12] = '{0, 1, 2, 3, 4, 6, 8, 10, 12, 15, 18, 21};
  int loop_base [4] = '{0, 1, 2, 4};
  int wrap_exp [6] = '{0, 513, 2, 515, 4, 517};

  initial begin
    int e;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    loop_en   = 1'b0;
    fcw_start = 32'h0040_0000;
    fcw_step  = 32'h0040_0000;
    n_steps   = 16'd3;
    dwell     = 24'd4;
    ch2_phase = 10'd0;

    // reset state
    repeat (2) @(negedge clk_125);
    chk("rst_busy", busy, 0);
    chk("rst_dac_en", dac_en, 0);
    chk("rst_done", done, 0);
    chk("rst_addr1", rom_addr1, 0);
    rst_n = 1'b1;
    @(negedge clk_125);

    // single pass; start and config changes mid-run must be ignored
    pulse_start();
    chk("sp_pre_busy", busy, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_125);
      start    = 1'b0;
      fcw_step = 32'h0040_0000;
      chk("sp_addr1", rom_addr1, exp1[i]);
      chk("sp_addr2", rom_addr2, exp1[i]);
      chk("sp_busy", busy, 1);
      chk("sp_dac_en", dac_en, 1);
      chk("sp_step", step_idx, i / 4);
      chk("sp_done", done, 0);
      if (i == 5) begin
        start    = 1'b1;
        fcw_step = 32'h0100_0000;
      end
    end
    @(negedge clk_125);
    chk("sp_done_pulse", done, 1);
    chk("sp_done_busy", busy, 0);
    chk("sp_done_dac_en", dac_en, 0);
    chk("sp_done_hold", rom_addr1, 21);
    @(negedge clk_125);
    chk("sp_done_end", done, 0);
    chk("sp_idle_busy", busy, 0);

    // phase offset on DA2
    ch2_phase = 10'd1023;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_125);
      chk("ph_addr1", rom_addr1, exp1[i]);
      e = (exp1[i] + 1023) % 1024;
      chk("ph_addr2", rom_addr2, e);
    end
    @(negedge clk_125);
    chk("ph_done", done, 1);
    @(negedge clk_125);

    // looping sweep, then clear loop_en live
    ch2_phase = 10'd0;
    loop_en   = 1'b1;
    n_steps   = 16'd2;
    dwell     = 24'd2;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_125);
      e = 6 * (i / 4) + loop_base[i % 4];
      chk("lp_addr1", rom_addr1, e);
      chk("lp_step", step_idx, (i % 4) / 2);
      chk("lp_busy", busy, 1);
      chk("lp_done", done, 0);
      if (i == 9) loop_en = 1'b0;
    end
    @(negedge clk_125);
    chk("lp_end_done", done, 1);
    chk("lp_end_busy", busy, 0);
    @(negedge clk_125);

    // zero n_steps/dwell behave as one single-cycle step
    n_steps   = 16'd0;
    dwell     = 24'd0;
    fcw_start = 32'h0080_0000;
    pulse_start();
    @(negedge clk_125);
    chk("zc_busy", busy, 1);
    chk("zc_addr1", rom_addr1, 0);
    chk("zc_step", step_idx, 0);
    @(negedge clk_125);
    chk("zc_done", done, 1);
    chk("zc_busy_off", busy, 0);
    @(negedge clk_125);
    chk("zc_done_end", done, 0);

    // abort on the 5th busy cycle, no done pulse, clean restart
    fcw_start = 32'h0040_0000;
    fcw_step  = 32'h0040_0000;
    n_steps   = 16'd3;
    dwell     = 24'd4;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_125);
      chk("ab_addr1", rom_addr1, exp1[i]);
    end
    abort = 1'b1;
    @(negedge clk_125);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_dac_en", dac_en, 0);
    chk("ab_done", done, 0);
    repeat (2) begin
      @(negedge clk_125);
      chk("ab_no_done", done, 0);
      chk("ab_idle", busy, 0);
    end
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_125);
      chk("ab_restart_addr1", rom_addr1, exp1[i]);
      chk("ab_restart_busy", busy, 1);
    end
    abort = 1'b1;
    @(negedge clk_125);
    abort = 1'b0;
    chk("ab2_busy", busy, 0);

    // start together with abort in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_125);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk_125);
    chk("sa_busy", busy, 0);
    chk("sa_dac_en", dac_en, 0);

    // accumulator wrap, then asynchronous reset mid-run
    fcw_start = 32'h8040_0000;
    fcw_step  = 32'h0;
    n_steps   = 16'd1;
    dwell     = 24'd100;
    ch2_phase = 10'd5;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_125);
      chk("wr_addr1", rom_addr1, wrap_exp[i]);
      e = (wrap_exp[i] + 5) % 1024;
      chk("wr_addr2", rom_addr2, e);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_dac_en", dac_en, 0);
    chk("ar_addr1", rom_addr1, 0);
    chk("ar_addr2", rom_addr2, 0);
    chk("ar_step", step_idx, 0);
    chk("ar_done", done, 0);
    @(negedge clk_125);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_125);
    chk("ar_post_busy", busy, 0);
    chk("ar_post_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
